mor1kx_tlb_reload_responder: RTL and testbench
==============================================

Name: mor1kx_tlb_reload_responder

Overview:
- Services hardware TLB-reload reads from the DMMU and IMMU. It is the responder on their req/addr/ack/data reload port.
- Arbitrates the two requesters round-robin and issues single-beat reads on a simple memory request bus.
- Returns each PTE-pointer or PTE word with a one-cycle ack.
- Holds the grant across consecutive reads of one page-table walk, so a two-level walk is atomic with respect to the other MMU.

Parameters:
- OPTION_OPERAND_WIDTH, 32, width of addresses and data.
- TIMEOUT_CYCLES, 255, maximum cycles waiting for a memory ack. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- d_req_i  in  1  DMMU reload request, held high for the whole walk.
- d_addr_i  in  OPTION_OPERAND_WIDTH  DMMU read address.
- d_ack_o  out  1  one-cycle response strobe to DMMU.
- d_data_o  out  OPTION_OPERAND_WIDTH  read data to DMMU, valid while d_ack_o is high.
- i_req_i  in  1  IMMU reload request.
- i_addr_i  in  OPTION_OPERAND_WIDTH  IMMU read address.
- i_ack_o  out  1  response strobe to IMMU.
- i_data_o  out  OPTION_OPERAND_WIDTH  read data to IMMU.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  OPTION_OPERAND_WIDTH  memory read address, word aligned.
- mem_ack_i  in  1  memory read complete.
- mem_err_i  in  1  memory read error, also completes the transfer.
- mem_data_i  in  OPTION_OPERAND_WIDTH  memory read data, valid with mem_ack_i.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, owner none, last_grant = I (so D wins first).
- States are IDLE, BUS, RESP, GAP. All outputs are registered.
- IDLE:
  - If exactly one req is high, grant that requester. If both are high, grant the one that is not last_grant.
  - Latch mem_addr_o = {owner_addr[31:2], 2'b00}, set mem_req_o=1, go to BUS.
  - Req seen at edge N gives mem_req_o high after edge N.
- BUS:
  - mem_req_o and mem_addr_o stay stable until mem_ack_i or mem_err_i is sampled high.
  - On that edge: mem_req_o<=0; latch data (mem_data_i on ack, all-zero on err).
  - If both mem_ack_i and mem_err_i are high, err wins and data is 0. A zero pointer makes the MMU raise a pagefault.
  - If owner req is still high: owner ack<=1, owner data<=latched value, go to RESP.
  - If owner req has dropped (MMU aborted): no ack, release owner, last_grant<=owner, go to IDLE.
- RESP: owner ack is high for exactly one cycle, with data valid. Then ack<=0 and go to GAP. Data outputs hold their value until the next response.
- GAP: one cycle, so the requester's updated address and req (changed on the ack edge) are sampled.
  - Owner req high: reissue mem_req_o with the new owner address, go to BUS. The other requester is never granted mid-walk.
  - Owner req low: release owner, last_grant<=owner, go to IDLE.
- The non-owner's ack is always 0. Requests from the non-owner wait without loss.
- Owner req dropping during RESP or GAP is legal (end of walk) and causes no further memory read.
- Back-to-back walks: the earliest re-grant is the cycle after GAP/IDLE. Minimum per-read latency is 3 cycles from req to ack with a 1-cycle memory.

Optional Feature:
- Macro: MOR1KX_TLB_RELOAD_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter, sized from TIMEOUT_CYCLES, clears on entry to BUS and increments each BUS cycle.
  - When it reaches TIMEOUT_CYCLES without a memory ack or err, drop mem_req_o and treat the read as an error: data 0, ack to owner if its req is still high.
  - A mem_ack_i arriving in a later cycle is ignored.
- Without the macro: no counter, and BUS waits indefinitely.

Test Plan:
- Single DMMU two-level walk:
  - Stimulus: d_req=1, d_addr=0x0000_1004; memory returns 0x0040_2000 after 2 cycles.
  - Required: d_ack pulse with 0x0040_2000. The DMMU changes d_addr to 0x0040_2010 at ack, and a second mem_req_o issues with addr 0x0040_2010 after GAP. That memory returns 0x1234_5400, which is acked, then d_req drops and the state returns to IDLE.
- Simultaneous d_req and i_req after reset:
  - DMMU is granted first. i_ack stays 0 through the whole DMMU walk, including GAP.
  - IMMU is granted in the cycle after the DMMU releases.
  - If both requesters assert again, IMMU loses the next tie (round-robin).
- mem_err_i=1 with mem_data_i=0xFFFF_FFFF: owner ack with data 0x0000_0000.
- Abort: d_req drops while in BUS, then mem_ack arrives. Required: no d_ack, mem_req_o low, IDLE next cycle, no second memory read.
- Async reset asserted mid-BUS: mem_req_o, d_ack_o and i_ack_o go to 0 immediately. After release, a new req restarts from IDLE with D priority.
- MOR1KX_TLB_RELOAD_TIMEOUT_EN, TIMEOUT_CYCLES=8, no memory ack: mem_req_o drops after 8 BUS cycles and the owner gets an ack with data 0. A late mem_ack_i is ignored.

Source files
------------

// File: rtl/mor1kx_tlb_reload_responder.sv
// TLB reload responder: serves DMMU/IMMU page-table reads on a memory bus.
// Ports: clk, rst_n, d_/i_ req/addr/ack/data, mem_ req/addr/ack/err/data; opt MOR1KX_TLB_RELOAD_TIMEOUT_EN.
module mor1kx_tlb_reload_responder #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            d_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] d_addr_i,
  output logic                            d_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] d_data_o,
  input  logic                            i_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] i_addr_i,
  output logic                            i_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] i_data_o,
  output logic                            mem_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mem_addr_o,
  input  logic                            mem_ack_i,
  input  logic                            mem_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mem_data_i
);

  localparam int W = OPTION_OPERAND_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_D,
    OWN_I
  } own_t;

  state_t state;
  own_t   owner;
  logic   last_i;

  logic [W-1:0] d_waddr;
  logic [W-1:0] i_waddr;
  logic         own_req;
  logic [W-1:0] own_addr;
  logic         pick_d;
  logic         pick_i;
  logic         bus_done;
  logic         bus_err;
  logic [W-1:0] rd_data;

  assign d_waddr = {d_addr_i[W-1:2], 2'b00};
  assign i_waddr = {i_addr_i[W-1:2], 2'b00};

  // Tie goes to whoever was not served last.
  assign pick_d = d_req_i & (~i_req_i | last_i);
  assign pick_i = i_req_i & (~d_req_i | ~last_i);

  always_comb begin
    own_req  = 1'b0;
    own_addr = '0;
    unique case (owner)
      OWN_D: begin
        own_req  = d_req_i;
        own_addr = d_waddr;
      end
      OWN_I: begin
        own_req  = i_req_i;
        own_addr = i_waddr;
      end
      default: ;
    endcase
  end

  logic unused_addr_bits;
  assign unused_addr_bits =
    ^{d_addr_i[1:0], i_addr_i[1:0]};

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW =
    (CW_RAW < 8)  ? 8  :
    (CW_RAW > 16) ? 16 : CW_RAW;

  logic [TW-1:0] tmo_cnt;
  logic          tmo;

  // Zero outside BUS, so every entry into BUS starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == BUS) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo = (state == BUS) &&
               (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign bus_done = mem_ack_i | mem_err_i | tmo;
  // A real ack on the expiry cycle still counts.
  assign bus_err  = mem_err_i | (tmo & ~mem_ack_i);
`else
  logic unused_tmo_param;
  assign unused_tmo_param = TIMEOUT_CYCLES[0];

  assign bus_done = mem_ack_i | mem_err_i;
  assign bus_err  = mem_err_i;
`endif

  // Error returns a null pointer so the MMU pagefaults.
  assign rd_data = bus_err ? '0 : mem_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      last_i     <= 1'b1;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      d_ack_o    <= 1'b0;
      d_data_o   <= '0;
      i_ack_o    <= 1'b0;
      i_data_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            pick_d: begin
              owner      <= OWN_D;
              mem_req_o  <= 1'b1;
              mem_addr_o <= d_waddr;
              state      <= BUS;
            end
            pick_i: begin
              owner      <= OWN_I;
              mem_req_o  <= 1'b1;
              mem_addr_o <= i_waddr;
              state      <= BUS;
            end
            default: ;
          endcase
        end

        BUS: begin
          if (bus_done) begin
            mem_req_o <= 1'b0;
            if (own_req) begin
              state <= RESP;
              if (owner == OWN_I) begin
                i_ack_o  <= 1'b1;
                i_data_o <= rd_data;
              end else begin
                d_ack_o  <= 1'b1;
                d_data_o <= rd_data;
              end
            end else begin
              // Walk aborted: drop data, release.
              owner  <= OWN_NONE;
              last_i <= (owner == OWN_I);
              state  <= IDLE;
            end
          end
        end

        RESP: begin
          d_ack_o <= 1'b0;
          i_ack_o <= 1'b0;
          state   <= GAP;
        end

        GAP: begin
          // Grant is held for the next level of the walk.
          if (own_req) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= own_addr;
            state      <= BUS;
          end else begin
            owner  <= OWN_NONE;
            last_i <= (owner == OWN_I);
            state  <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_tlb_reload_responder.sv
// Bench for mor1kx_tlb_reload_responder.
// Scoreboarded memory model and ack monitor.
module tb_mor1kx_tlb_reload_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_ack_o;
  logic [31:0] d_data_o;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack_o;
  logic [31:0] i_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [31:0] mem_data_i = '0;

  always #5 clk = ~clk;

  mor1kx_tlb_reload_responder #(
    .OPTION_OPERAND_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .d_req_i(d_req),
    .d_addr_i(d_addr),
    .d_ack_o(d_ack_o),
    .d_data_o(d_data_o),
    .i_req_i(i_req),
    .i_addr_i(i_addr),
    .i_ack_o(i_ack_o),
    .i_data_o(i_data_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i),
    .mem_err_i(mem_err_i),
    .mem_data_i(mem_data_i)
  );

  int n_checks = 0;
  int n_fails = 0;

  logic [31:0] addr_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] i_exp_q[$];

  // mem_mode: 0 ack, 1 err, 2 ack+err, 3 never respond
  int mem_lat = 1;
  int mem_mode = 0;
  bit late_ack = 1'b0;
  int mem_cnt = 0;
  int req_count = 0;
  int d_ack_cnt = 0;
  int i_ack_cnt = 0;
  bit d_prev = 1'b0;
  bit i_prev = 1'b0;
  logic [31:0] ea;
  logic [31:0] ed;
  logic [31:0] ei;

  // Memory model
  always @(negedge clk) begin
    mem_ack_i  = 1'b0;
    mem_err_i  = 1'b0;
    mem_data_i = '0;
    if (late_ack) begin
      mem_ack_i  = 1'b1;
      mem_data_i = 32'hDEAD_BEEF;
      late_ack   = 1'b0;
    end else if (!mem_req_o) begin
      mem_cnt = 0;
    end else begin
      mem_cnt++;
      if (mem_cnt == 1) begin
        req_count++;
        n_checks++;
        if (addr_q.size() == 0) begin
          n_fails++;
          $display("FAIL mem_addr_unexpected got %h", mem_addr_o);
        end else begin
          ea = addr_q.pop_front();
          if (mem_addr_o !== ea) begin
            n_fails++;
            $display("FAIL mem_addr got %h want %h", mem_addr_o, ea);
          end
        end
      end
      if (mem_cnt == mem_lat && mem_mode != 3) begin
        mem_data_i = (mem_q.size() != 0) ? mem_q.pop_front() : '0;
        mem_ack_i  = (mem_mode == 0 || mem_mode == 2);
        mem_err_i  = (mem_mode == 1 || mem_mode == 2);
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (d_ack_o) begin
      d_ack_cnt++;
      n_checks++;
      if (d_prev) begin
        n_fails++;
        $display("FAIL d_ack_width got 2+ cycles want 1");
      end
      n_checks++;
      if (d_exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL d_ack_unexpected got %h", d_data_o);
      end else begin
        ed = d_exp_q.pop_front();
        if (d_data_o !== ed) begin
          n_fails++;
          $display("FAIL d_data got %h want %h", d_data_o, ed);
        end
      end
    end
    if (i_ack_o) begin
      i_ack_cnt++;
      n_checks++;
      if (i_prev) begin
        n_fails++;
        $display("FAIL i_ack_width got 2+ cycles want 1");
      end
      n_checks++;
      if (i_exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL i_ack_unexpected got %h", i_data_o);
      end else begin
        ei = i_exp_q.pop_front();
        if (i_data_o !== ei) begin
          n_fails++;
          $display("FAIL i_data got %h want %h", i_data_o, ei);
        end
      end
    end
    d_prev = d_ack_o;
    i_prev = i_ack_o;
  end

  task automatic wait_ack(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (is_d ? d_ack_o : i_ack_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mreq(input bit lvl, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_req_o == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req_o, d_ack_o, i_ack_o} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_strobes got %b want 000",
               {mem_req_o, d_ack_o, i_ack_o});
    end
    n_checks++;
    if ({mem_addr_o, d_data_o, i_data_o} !== 96'd0) begin
      n_fails++;
      $display("FAIL reset_data got %h %h %h want 0",
               mem_addr_o, d_data_o, i_data_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_walk;
    bit ok;
    int base;
    base = req_count;
    mem_lat = 2;
    mem_mode = 0;
    addr_q.push_back(32'h0000_1004);
    addr_q.push_back(32'h0040_2010);
    mem_q.push_back(32'h0040_2000);
    mem_q.push_back(32'h1234_5400);
    d_exp_q.push_back(32'h0040_2000);
    d_exp_q.push_back(32'h1234_5400);
    d_addr = 32'h0000_1004;
    d_req = 1'b1;
    wait_ack(1'b1, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL walk_ack1 got timeout want ack");
    end
    d_addr = 32'h0040_2010;
    wait_ack(1'b1, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL walk_ack2 got timeout want ack");
    end
    d_req = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b0 || req_count - base != 2) begin
      n_fails++;
      $display("FAIL walk_end got req=%b reads=%0d want 0 2",
               mem_req_o, req_count - base);
    end
    mem_lat = 1;
  endtask

  // Both request together; first_d selects expected winner.
  task automatic test_tie(input bit first_d,
                          input logic [31:0] da,
                          input logic [31:0] ia,
                          input logic [31:0] dv,
                          input logic [31:0] iv);
    bit ok;
    int other;
    if (first_d) begin
      addr_q.push_back(da);
      addr_q.push_back(ia);
      mem_q.push_back(dv);
      mem_q.push_back(iv);
    end else begin
      addr_q.push_back(ia);
      addr_q.push_back(da);
      mem_q.push_back(iv);
      mem_q.push_back(dv);
    end
    d_exp_q.push_back(dv);
    i_exp_q.push_back(iv);
    other = first_d ? i_ack_cnt : d_ack_cnt;
    d_addr = da;
    i_addr = ia;
    d_req = 1'b1;
    i_req = 1'b1;
    wait_ack(first_d, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL tie_first_ack got timeout want ack");
    end
    if (first_d) d_req = 1'b0;
    else i_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ((first_d ? i_ack_cnt : d_ack_cnt) != other ||
        mem_req_o !== 1'b0) begin
      n_fails++;
      $display("FAIL tie_hold got other_acks=%0d req=%b want %0d 0",
               first_d ? i_ack_cnt : d_ack_cnt, mem_req_o, other);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_fails++;
      $display("FAIL tie_regrant got req=%b want 1", mem_req_o);
    end
    wait_ack(!first_d, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL tie_second_ack got timeout want ack");
    end
    d_req = 1'b0;
    i_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic single_read(input bit is_d,
                             input logic [31:0] a,
                             input logic [31:0] md,
                             input logic [31:0] ex,
                             input int mode);
    bit ok;
    mem_mode = mode;
    addr_q.push_back(a & 32'hFFFF_FFFC);
    mem_q.push_back(md);
    if (is_d) begin
      d_exp_q.push_back(ex);
      d_addr = a;
      d_req = 1'b1;
    end else begin
      i_exp_q.push_back(ex);
      i_addr = a;
      i_req = 1'b1;
    end
    wait_ack(is_d, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL read_ack got timeout want ack");
    end
    d_req = 1'b0;
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b0) begin
      n_fails++;
      $display("FAIL read_idle got req=%b want 0", mem_req_o);
    end
    mem_mode = 0;
  endtask

  task automatic test_round_robin;
    test_tie(1'b1, 32'h0000_8000, 32'h0000_9000,
             32'h0000_0A11, 32'h0000_0B22);
    single_read(1'b1, 32'h0000_8100, 32'h0000_0C33,
                32'h0000_0C33, 0);
    test_tie(1'b0, 32'h0000_8200, 32'h0000_9200,
             32'h0000_0D44, 32'h0000_0E55);
  endtask

  task automatic test_err;
    single_read(1'b1, 32'h0000_3000, 32'hFFFF_FFFF,
                32'h0000_0000, 1);
    single_read(1'b0, 32'h0000_2003, 32'hFFFF_FFFF,
                32'h0000_0000, 2);
    single_read(1'b0, 32'h0000_2007, 32'h0000_CAFE,
                32'h0000_CAFE, 0);
  endtask

  task automatic test_abort;
    bit ok;
    int base;
    int acks;
    base = req_count;
    acks = d_ack_cnt;
    mem_lat = 3;
    addr_q.push_back(32'h0000_5000);
    mem_q.push_back(32'h1111_1111);
    d_addr = 32'h0000_5000;
    d_req = 1'b1;
    wait_mreq(1'b1, ok);
    @(negedge clk);
    d_req = 1'b0;
    wait_mreq(1'b0, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL abort_req_drop got timeout want 0");
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (d_ack_cnt != acks || mem_req_o !== 1'b0 ||
        req_count - base != 1) begin
      n_fails++;
      $display("FAIL abort got acks=%0d req=%b reads=%0d want 0 0 1",
               d_ack_cnt - acks, mem_req_o, req_count - base);
    end
    mem_lat = 1;
  endtask

  task automatic test_reset_mid_bus;
    bit ok;
    mem_lat = 5;
    addr_q.push_back(32'h0000_6000);
    d_addr = 32'h0000_6000;
    d_req = 1'b1;
    wait_mreq(1'b1, ok);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req_o, d_ack_o, i_ack_o} !== 3'b000) begin
      n_fails++;
      $display("FAIL async_reset got %b want 000",
               {mem_req_o, d_ack_o, i_ack_o});
    end
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 1;
    @(negedge clk);
    test_tie(1'b1, 32'h0000_6100, 32'h0000_6200,
             32'h0000_0F66, 32'h0000_0F77);
  endtask

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int hi;
    int base;
    int acks;
    base = req_count;
    acks = d_ack_cnt;
    mem_mode = 3;
    addr_q.push_back(32'h0000_7000);
    d_exp_q.push_back(32'h0000_0000);
    d_addr = 32'h0000_7000;
    d_req = 1'b1;
    wait_mreq(1'b1, ok);
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!mem_req_o) break;
      hi++;
    end
    n_checks++;
    if (hi != 8 || d_ack_o !== 1'b1) begin
      n_fails++;
      $display("FAIL timeout got cycles=%0d ack=%b want 8 1",
               hi, d_ack_o);
    end
    late_ack = 1'b1;
    d_req = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (d_ack_cnt - acks != 1 || mem_req_o !== 1'b0 ||
        req_count - base != 1) begin
      n_fails++;
      $display("FAIL late_ack got acks=%0d req=%b reads=%0d want 1 0 1",
               d_ack_cnt - acks, mem_req_o, req_count - base);
    end
    mem_mode = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_walk();
    test_reset();
    test_tie(1'b1, 32'h0000_A000, 32'h0000_B000,
             32'h0000_0111, 32'h0000_0222);
    test_round_robin();
    test_err();
    test_abort();
    test_reset_mid_bus();
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    n_checks++;
    if (addr_q.size() + d_exp_q.size() + i_exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL leftover got addr=%0d d=%0d i=%0d want 0",
               addr_q.size(), d_exp_q.size(), i_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
